// File: rtl/pb_event.sv
// Push-button event generator: synchronizes a debounced button level into the
// clk domain and emits press / release / long-press / auto-repeat strobes.
// The release strobe is on release_pulse because "release" is a reserved word.
module pb_event #(
    parameter int CLK_PER_MS = 100000,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200,
    parameter int HOLD_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pb_level,
    output logic              press,
    output logic              release_pulse,
    output logic              long_press,
    output logic              repeat_pulse,
    output logic              held,
    output logic [HOLD_W-1:0] hold_ms
);

    localparam int PRE_W = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
    localparam int REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_MS - 1);
    localparam logic [HOLD_W-1:0] LONG_CNT  = HOLD_W'(LONG_MS);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        LONG
    } state_t;

    state_t            state;
    logic              sync1;
    logic              sync2;
    logic [PRE_W-1:0]  prescale;
    logic [REP_W-1:0]  rep_cnt;

    logic              rise;
    logic              fall;
    logic              ms_wrap;
    logic [HOLD_W-1:0] hold_next;

    assign rise      = sync2 & ~held;
    assign fall      = ~sync2 & held;
    assign ms_wrap   = (prescale == PRE_LAST);
    assign hold_next = (hold_ms == '1) ? hold_ms : hold_ms + 1'b1;

    // NOTE: all state here is updated with <= so every register sees the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            held          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            hold_ms       <= '0;
            prescale      <= '0;
            rep_cnt       <= '0;
            state         <= IDLE;
        end else begin
            sync1         <= pb_level;
            sync2         <= sync1;
            held          <= sync2;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        press    <= 1'b1;
                        prescale <= '0;
                        hold_ms  <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD, LONG: begin
                    // A fall outranks any ms wrap landing in the same cycle.
                    if (fall) begin
                        release_pulse <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        prescale <= ms_wrap ? '0 : prescale + 1'b1;
                        if (ms_wrap) begin
                            hold_ms <= hold_next;
                            if (state == HOLD) begin
                                if (hold_next == LONG_CNT) begin
                                    long_press <= 1'b1;
                                    rep_cnt    <= '0;
                                    state      <= LONG;
                                end
                            end else if (rep_cnt == REP_LAST) begin
                                repeat_pulse <= 1'b1;
                                rep_cnt      <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_event.sv
// Self-checking bench for pb_event: directed scenarios with literal timing
// expectations plus randomized button levels against an event-time model.
module tb_pb_event;

    localparam int CPM  = 4;
    localparam int LMS  = 3;
    localparam int RMS  = 2;
    localparam int HW   = 4;
    localparam int HMAX = (1 << HW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pb_level = 1'b0;
    logic          press;
    logic          release_pulse;
    logic          long_press;
    logic          repeat_pulse;
    logic          held;
    logic [HW-1:0] hold_ms;

    pb_event #(
        .CLK_PER_MS(CPM),
        .LONG_MS   (LMS),
        .REPEAT_MS (RMS),
        .HOLD_W    (HW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_level     (pb_level),
        .press        (press),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .hold_ms      (hold_ms)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at edge", name, act, exp);
        end
    endtask

    // Behavioural model: the button level reaches "held" after three edges;
    // every strobe and hold_ms is derived from the elapsed time since press.
    longint cyc = 0;
    bit     dly0, dly1, m_held, prev_h;
    bit     m_pressed;
    longint m_p;
    longint m_d;
    int     m_hold;
    bit     m_press, m_rel, m_long, m_rep;

    always @(posedge clk) begin
        cyc++;
        m_press = 0;
        m_rel   = 0;
        m_long  = 0;
        m_rep   = 0;
        if (rst) begin
            dly0      = 0;
            dly1      = 0;
            m_held    = 0;
            m_pressed = 0;
            m_hold    = 0;
        end else begin
            prev_h = m_held;
            m_held = dly1;
            dly1   = dly0;
            dly0   = pb_level;
            if (m_held && !prev_h) begin
                m_press   = 1;
                m_pressed = 1;
                m_p       = cyc;
                m_hold    = 0;
            end else if (!m_held && prev_h) begin
                m_rel     = 1;
                m_pressed = 0;
            end else if (m_pressed) begin
                m_d    = cyc - m_p;
                m_hold = (m_d / CPM > HMAX) ? HMAX : int'(m_d / CPM);
                m_long = (m_d == LMS * CPM);
                m_rep  = (m_d > LMS * CPM) && ((m_d - LMS * CPM) % (RMS * CPM) == 0);
            end
        end
    end

    // Observed event times, cleared per directed scenario; totals are not.
    longint press_q[$], rel_q[$], long_q[$], rep_q[$];
    int     tot_press = 0, tot_rel = 0;
    logic [3:0] prev_vec = 4'b0;
    logic [3:0] cur_vec;

    always @(negedge clk) begin
        check("press",        press,         m_press);
        check("release",      release_pulse, m_rel);
        check("long_press",   long_press,    m_long);
        check("repeat_pulse", repeat_pulse,  m_rep);
        check("held",         held,          m_held);
        check("hold_ms",      hold_ms,       m_hold);
        cur_vec = {press, release_pulse, long_press, repeat_pulse};
        check("one_hot",      $countones(cur_vec) > 1, 0);
        check("no_back2back", cur_vec & prev_vec, 0);
        prev_vec = cur_vec;
        if (press)         begin press_q.push_back(cyc); tot_press++; end
        if (release_pulse) begin rel_q.push_back(cyc);   tot_rel++;   end
        if (long_press)    long_q.push_back(cyc);
        if (repeat_pulse)  rep_q.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        press_q.delete();
        rel_q.delete();
        long_q.delete();
        rep_q.delete();
    endtask

    longint e0;
    longint p0;
    bit     lvl;

    initial begin
        step(3);
        check("reset_hold_ms", hold_ms, 0);
        check("reset_held",    held,    0);
        rst = 1'b0;
        step(5);

        // Hold for 40 cycles: press +3, long +12, repeats +20/+28/+36, release +40.
        clear_q();
        e0 = cyc;
        pb_level = 1'b1;
        step(40);
        pb_level = 1'b0;
        step(10);
        check("d1_press_count", press_q.size(), 1);
        check("d1_press_lat",   press_q[0] - e0, 3);
        p0 = press_q[0];
        check("d1_long_count",  long_q.size(), 1);
        check("d1_long_time",   long_q[0] - p0, 12);
        check("d1_rep_count",   rep_q.size(), 3);
        check("d1_rep0",        rep_q[0] - p0, 20);
        check("d1_rep1",        rep_q[1] - p0, 28);
        check("d1_rep2",        rep_q[2] - p0, 36);
        check("d1_rel_time",    rel_q[0] - p0, 40);

        // Short press of 6 cycles.
        clear_q();
        pb_level = 1'b1;
        step(6);
        pb_level = 1'b0;
        step(8);
        check("short_gap",     rel_q[0] - press_q[0], 6);
        check("short_long",    long_q.size(), 0);
        check("short_rep",     rep_q.size(), 0);
        check("short_hold_ms", hold_ms, 1);

        // Fall detect lands on the long_press wrap: release only.
        clear_q();
        pb_level = 1'b1;
        step(12);
        pb_level = 1'b0;
        step(8);
        check("tie_gap",  rel_q[0] - press_q[0], 12);
        check("tie_long", long_q.size(), 0);
        check("tie_rep",  rep_q.size(), 0);

        // 80-cycle hold: saturation and steady repeats.
        clear_q();
        pb_level = 1'b1;
        step(80);
        check("sat_hold_ms", hold_ms, 15);
        pb_level = 1'b0;
        step(8);
        check("sat_rep_count", rep_q.size(), 8);
        for (int i = 1; i < rep_q.size(); i++)
            check("sat_rep_period", rep_q[i] - rep_q[i-1], 8);
        check("sat_hold_final", hold_ms, 15);

        // Reset during LONG with the button still held.
        clear_q();
        pb_level = 1'b1;
        step(20);
        check("rst_in_long", long_q.size(), 1);
        rst = 1'b1;
        step(1);
        check("rst_outputs", {press, release_pulse, long_press, repeat_pulse, held}, 0);
        check("rst_hold_ms", hold_ms, 0);
        rst = 1'b0;
        e0 = cyc;
        step(6);
        check("rst_repress_count", press_q.size(), 2);
        check("rst_repress_lat",   press_q[1] - e0, 3);
        check("rst_no_release",    rel_q.size(), 0);
        pb_level = 1'b0;
        step(8);

        // Randomized levels, changes at least 3 cycles apart.
        tot_press = 0;
        tot_rel   = 0;
        lvl = 1'b0;
        for (int i = 0; i < 150; i++) begin
            lvl = ~lvl;
            pb_level = lvl;
            step(int'($urandom_range(3, 45)));
        end
        pb_level = 1'b0;
        step(10);
        check("rand_press_eq_release", tot_press, tot_rel);
        check("rand_press_count", tot_press, 75);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
